// File: rtl/accum_seq_pkg.sv
// Shared types and sizing for the accumulation frame sequencer.
package accum_seq_pkg;

  localparam int unsigned FRAME_LEN_DFLT = 128;
  localparam int unsigned AVG_W_DFLT     = 8;
  localparam int unsigned CNT_W          = $clog2(FRAME_LEN_DFLT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/accum_frame_sequencer_if.sv
// Stream handshake bundle between FFT source, accumulator and downstream sink.
interface accum_frame_sequencer_if;

  logic i_s_valid;
  logic o_s_ready;
  logic i_acc_ready;
  logic o_acc_wr;
  logic o_acc_first;
  logic o_acc_last;
  logic i_m_valid;
  logic i_m_ready;
  logic o_m_valid;

  // Sequencer side
  modport master (
    input  i_s_valid, i_acc_ready, i_m_valid, i_m_ready,
    output o_s_ready, o_acc_wr, o_acc_first, o_acc_last, o_m_valid
  );

  // Environment side (FFT source, accumulator, sink)
  modport slave (
    output i_s_valid, i_acc_ready, i_m_valid, i_m_ready,
    input  o_s_ready, o_acc_wr, o_acc_first, o_acc_last, o_m_valid
  );

endinterface

// File: rtl/frame_beat_counter.sv
// Free-running beat counter with clear priority and terminal-count flag at all-ones.
module frame_beat_counter #(
  parameter int unsigned CNT_W = 7
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] cnt_q;

  // Wraps to zero naturally because the frame length is a power of two
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_tc = (cnt_q == '1);

endmodule

// File: rtl/accum_frame_sequencer.sv
// Sequences N-frame accumulation of the FFT stream followed by a single drain.
// Optional sticky overrun detection: define ACCUM_FRAME_SEQ_OVERRUN_DET_EN.
module accum_frame_sequencer
  import accum_seq_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DFLT,
  parameter int unsigned AVG_W     = AVG_W_DFLT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [AVG_W-1:0]     i_num_avg,
  accum_frame_sequencer_if.master bus_if,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_flush,
  output logic [AVG_W-1:0]     o_frame_idx,
  output logic                 o_overrun
);

  localparam int unsigned BEAT_W = $clog2(FRAME_LEN);

  state_e           state_q, state_d;
  logic [AVG_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [AVG_W-1:0] num_avg_q, num_avg_d;
  logic             done_q, done_d;
  logic             flush_q, flush_d;
  logic             beat_clr, drain_clr;
  logic             beat_tc, drain_tc;
  logic             acc_wr, drain_fire, last_frame;

  // Zero-latency gating from registered state
  assign bus_if.o_s_ready   = bus_if.i_acc_ready & (state_q == ACCUM);
  assign acc_wr             = bus_if.i_s_valid & bus_if.o_s_ready;
  assign bus_if.o_acc_wr    = acc_wr;
  assign bus_if.o_m_valid   = bus_if.i_m_valid & (state_q == DRAIN);
  assign drain_fire         = bus_if.o_m_valid & bus_if.i_m_ready;
  assign last_frame         = (frame_cnt_q == (num_avg_q - AVG_W'(1)));
  assign bus_if.o_acc_first = (state_q == ACCUM) & (frame_cnt_q == '0);
  assign bus_if.o_acc_last  = (state_q == ACCUM) & last_frame;

  assign o_busy      = (state_q != IDLE);
  assign o_done      = done_q;
  assign o_flush     = flush_q;
  assign o_frame_idx = frame_cnt_q;

  frame_beat_counter #(.CNT_W(BEAT_W)) u_beat_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (beat_clr),
    .i_en    (acc_wr),
    .o_tc    (beat_tc)
  );

  frame_beat_counter #(.CNT_W(BEAT_W)) u_drain_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (drain_clr),
    .i_en    (drain_fire),
    .o_tc    (drain_tc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      num_avg_q   <= '0;
      done_q      <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      num_avg_q   <= num_avg_d;
      done_q      <= done_d;
      flush_q     <= flush_d;
    end
  end

  // Abort has priority over every state transition, including a same-cycle start
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    num_avg_d   = num_avg_q;
    done_d      = 1'b0;
    flush_d     = 1'b0;
    beat_clr    = 1'b0;
    drain_clr   = 1'b0;

    if (i_abort) begin
      state_d     = IDLE;
      flush_d     = 1'b1;
      frame_cnt_d = '0;
      beat_clr    = 1'b1;
      drain_clr   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d     = ACCUM;
            num_avg_d   = (i_num_avg == '0) ? AVG_W'(1) : i_num_avg;
            frame_cnt_d = '0;
            beat_clr    = 1'b1;
            drain_clr   = 1'b1;
          end
        end
        ACCUM: begin
          if (acc_wr && beat_tc) begin
            if (last_frame) begin
              state_d     = DRAIN;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + AVG_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_fire && drain_tc) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef ACCUM_FRAME_SEQ_OVERRUN_DET_EN
  logic overrun_q;

  // Source producing while the accumulator is being drained means lost data
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      overrun_q <= 1'b0;
    end else if ((state_q == IDLE) && i_start && !i_abort) begin
      overrun_q <= 1'b0;
    end else if ((state_q == DRAIN) && bus_if.i_s_valid) begin
      overrun_q <= 1'b1;
    end
  end

  assign o_overrun = overrun_q;
`else
  assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_accum_frame_sequencer.sv
// Directed self-checking bench for accum_frame_sequencer (FRAME_LEN=128, AVG_W=8).
module tb_accum_frame_sequencer;

  localparam int FL = 128;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_abort;
  logic [7:0] i_num_avg;
  logic       o_busy;
  logic       o_done;
  logic       o_flush;
  logic [7:0] o_frame_idx;
  logic       o_overrun;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef ACCUM_FRAME_SEQ_OVERRUN_DET_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  accum_frame_sequencer_if bus();

  accum_frame_sequencer #(.FRAME_LEN(FL), .AVG_W(8)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_num_avg   (i_num_avg),
    .bus_if      (bus),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_flush     (o_flush),
    .o_frame_idx (o_frame_idx),
    .o_overrun   (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    i_start   = 1'b1;
    i_num_avg = n;
    tick();
    i_start   = 1'b0;
    i_num_avg = 8'd0;
  endtask

  // Accept beats idx0..total-1; tags follow the beat index
  task automatic run_accum(input int idx0, input int total, input int navg, input bit rnd);
    int idx = idx0;
    int cyc = 0;
    int fr;
    bus.i_m_valid = 1'b0;
    while (idx < total && cyc < 5000) begin
      bus.i_s_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_acc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      chk("acc_wr", 32'(bus.o_acc_wr), 32'(bus.i_s_valid & bus.i_acc_ready));
      if (bus.o_acc_wr) begin
        fr = idx / FL;
        chk("acc_first", 32'(bus.o_acc_first), 32'(fr == 0));
        chk("acc_last", 32'(bus.o_acc_last), 32'(fr == navg - 1));
        chk("frame_idx", 32'(o_frame_idx), 32'(fr));
        idx++;
      end
      tick();
      cyc++;
    end
    bus.i_s_valid   = 1'b0;
    bus.i_acc_ready = 1'b1;
    chk("accum_count", 32'(idx), 32'(total));
  endtask

  // Drain FRAME_LEN beats, then expect one done pulse with busy low
  task automatic run_drain(input bit rnd);
    int cnt = 0;
    int cyc = 0;
    bus.i_s_valid = 1'b0;
    #3;
    chk("drain_s_ready", 32'(bus.o_s_ready), 32'd0);
    chk("drain_busy", 32'(o_busy), 32'd1);
    tick();
    while (cnt < FL && cyc < 5000) begin
      bus.i_m_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      chk("m_valid", 32'(bus.o_m_valid), 32'(bus.i_m_valid));
      chk("done_early", 32'(o_done), 32'd0);
      if (bus.o_m_valid && bus.i_m_ready) cnt++;
      tick();
      cyc++;
    end
    bus.i_m_valid = 1'b0;
    chk("drain_count", 32'(cnt), 32'(FL));
    #3;
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("done_busy", 32'(o_busy), 32'd0);
    tick();
    #3;
    chk("done_clear", 32'(o_done), 32'd0);
    tick();
  endtask

  initial begin
    i_rst_n         = 1'b0;
    i_start         = 1'b0;
    i_abort         = 1'b0;
    i_num_avg       = 8'd0;
    bus.i_s_valid   = 1'b0;
    bus.i_acc_ready = 1'b1;
    bus.i_m_valid   = 1'b0;
    bus.i_m_ready   = 1'b1;
    tick();
    tick();
    #3;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_flush", 32'(o_flush), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    chk("rst_frame_idx", 32'(o_frame_idx), 32'd0);
    chk("rst_s_ready", 32'(bus.o_s_ready), 32'd0);
    i_rst_n = 1'b1;
    tick();

    // Two frames, no backpressure
    do_start(8'd2);
    #3;
    chk("t1_busy", 32'(o_busy), 32'd1);
    tick();
    run_accum(0, 2 * FL, 2, 1'b0);
    run_drain(1'b0);

    // Zero count behaves as one frame
    do_start(8'd0);
    run_accum(0, FL, 1, 1'b0);
    run_drain(1'b0);

    // Three frames with random backpressure on both sides
    do_start(8'd3);
    run_accum(0, 3 * FL, 3, 1'b1);
    run_drain(1'b1);

    // Abort in the middle of frame 1
    do_start(8'd3);
    run_accum(0, FL + 70, 3, 1'b0);
    #3;
    chk("t4_frame_idx", 32'(o_frame_idx), 32'd1);
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    #3;
    chk("t4_flush", 32'(o_flush), 32'd1);
    chk("t4_busy", 32'(o_busy), 32'd0);
    chk("t4_s_ready", 32'(bus.o_s_ready), 32'd0);
    chk("t4_frame_clr", 32'(o_frame_idx), 32'd0);
    tick();
    #3;
    chk("t4_flush_clear", 32'(o_flush), 32'd0);
    chk("t4_no_done", 32'(o_done), 32'd0);
    tick();
    do_start(8'd2);
    bus.i_s_valid = 1'b1;
    #3;
    chk("t4_restart_idx", 32'(o_frame_idx), 32'd0);
    chk("t4_restart_first", 32'(bus.o_acc_first), 32'd1);
    bus.i_s_valid = 1'b0;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    tick();

    // Start and abort together in IDLE; start during ACCUM is ignored
    i_start   = 1'b1;
    i_abort   = 1'b1;
    i_num_avg = 8'd2;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    #3;
    chk("t5_idle_busy", 32'(o_busy), 32'd0);
    chk("t5_idle_flush", 32'(o_flush), 32'd1);
    tick();
    do_start(8'd2);
    run_accum(0, 10, 2, 1'b0);
    do_start(8'd5);
    #3;
    chk("t5_ign_busy", 32'(o_busy), 32'd1);
    chk("t5_ign_idx", 32'(o_frame_idx), 32'd0);
    tick();
    run_accum(10, 2 * FL, 2, 1'b0);
    run_drain(1'b0);

    // Source valid during drain
    do_start(8'd1);
    run_accum(0, FL, 1, 1'b0);
    bus.i_s_valid = 1'b1;
    tick();
    bus.i_s_valid = 1'b0;
    #3;
    chk("t6_overrun_set", 32'(o_overrun), 32'(EXP_OVR));
    tick();
    run_drain(1'b0);
    #3;
    chk("t6_overrun_hold", 32'(o_overrun), 32'(EXP_OVR));
    tick();
    do_start(8'd1);
    #3;
    chk("t6_overrun_clr", 32'(o_overrun), 32'd0);
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    tick();

    // Reset in the middle of a run
    do_start(8'd3);
    run_accum(0, 5, 3, 1'b0);
    i_rst_n = 1'b0;
    tick();
    #3;
    chk("mr_busy", 32'(o_busy), 32'd0);
    chk("mr_flush", 32'(o_flush), 32'd0);
    chk("mr_done", 32'(o_done), 32'd0);
    chk("mr_frame_idx", 32'(o_frame_idx), 32'd0);
    chk("mr_s_ready", 32'(bus.o_s_ready), 32'd0);
    i_rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
